// File: rtl/cond_sel_pkg.sv
// cond_sel_pkg: shared constants for the conditional-select pipeline.
// Holds the mode encoding and mode width used by core and top.
package cond_sel_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_PASS   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_CLAMP  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_THRESH = 2'd2;
    localparam logic [MODE_W-1:0] MODE_ABS    = 2'd3;

endpackage

// File: rtl/cond_sel_core.sv
// cond_sel_core: combinational transform (pass/clamp/thresh/abs).
// Ports: data_i, mode_i, lo_i, hi_i in; result_o, hit_o (result != data) out.
module cond_sel_core
    import cond_sel_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]  data_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [WIDTH-1:0]  lo_i,
    input  logic [WIDTH-1:0]  hi_i,
    output logic [WIDTH-1:0]  result_o,
    output logic              hit_o
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

    always_comb begin
        result_o = data_i;
        unique case (mode_i)
            MODE_PASS: result_o = data_i;
            MODE_CLAMP: begin
                // lo is tested first so lo > hi still has a defined result
                if (data_i < lo_i) begin
                    result_o = lo_i;
                end else if (data_i > hi_i) begin
                    result_o = hi_i;
                end
            end
            MODE_THRESH: begin
                if (data_i < lo_i) begin
                    result_o = '0;
                end
            end
            MODE_ABS: begin
                // negating the most negative value would wrap onto itself
                if (data_i == MOST_NEG) begin
                    result_o = MOST_POS;
                end else if (data_i[WIDTH-1]) begin
                    result_o = -data_i;
                end
            end
        endcase
        hit_o = (result_o != data_i);
    end

endmodule

// File: rtl/cond_sel_pipe.sv
// cond_sel_pipe: 2-stage valid/ready pipeline around cond_sel_core.
// Ports: in_* sample + handshake, out_* result + handshake, cnt_clr/hit_cnt.
module cond_sel_pipe
    import cond_sel_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [WIDTH-1:0]  in_lo,
    input  logic [WIDTH-1:0]  in_hi,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_hit,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              s1_valid_q;
    logic [WIDTH-1:0]  s1_data_q;
    logic [MODE_W-1:0] s1_mode_q;
    logic [WIDTH-1:0]  s1_lo_q;
    logic [WIDTH-1:0]  s1_hi_q;

    logic              s2_valid_q;
    logic [WIDTH-1:0]  s2_data_q;
    logic              s2_hit_q;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic [WIDTH-1:0]  core_result;
    logic              core_hit;
    logic              s2_adv;
    logic              s1_adv;
    logic              out_xfer;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_xfer = s2_valid_q && out_ready;

    cond_sel_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .data_i   (s1_data_q),
        .mode_i   (s1_mode_q),
        .lo_i     (s1_lo_q),
        .hi_i     (s1_hi_q),
        .result_o (core_result),
        .hit_o    (core_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= MODE_PASS;
            s1_lo_q    <= '0;
            s1_hi_q    <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= in_data;
                s1_mode_q <= in_mode;
                s1_lo_q   <= in_lo;
                s1_hi_q   <= in_hi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_hit_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= core_result;
                s2_hit_q  <= core_hit;
            end
        end
    end

    // clear beats a coincident counted transfer
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_xfer && s2_hit_q && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_data  = s2_data_q;
    assign out_hit   = s2_hit_q;
    assign out_valid = s2_valid_q;
    assign hit_cnt   = cnt_q;

endmodule

// File: tb/tb_cond_sel_pipe.sv
// tb_cond_sel_pipe: directed + random bench for cond_sel_pipe.
// Reference model: integer transform rules plus an expected-output queue.
module tb_cond_sel_pipe;

    localparam int W    = 4;
    localparam int CW   = 8;
    localparam int FULL = 1 << W;
    localparam int HALF = 1 << (W - 1);
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic [1:0]    in_mode = '0;
    logic [W-1:0]  in_lo = '0;
    logic [W-1:0]  in_hi = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_hit;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] hit_cnt;

    typedef struct {
        int data;
        int hit;
        int cyc;
    } exp_t;

    exp_t   q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     cnt_m = 0;
    bit     lat_chk = 1'b0;
    bit     last_acc = 1'b0;
    bit     prev_hold = 1'b0;
    logic [W-1:0] prev_od;
    logic   prev_oh;

    cond_sel_pipe #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_lo     (in_lo),
        .in_hi     (in_hi),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_hit   (out_hit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_clr   (cnt_clr),
        .hit_cnt   (hit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic int ref_xform(int d, int m, int lo, int hi);
        int sd;
        int a;
        case (m)
            1: begin
                if (d < lo) return lo;
                if (d > hi) return hi;
                return d;
            end
            2: return (d >= lo) ? d : 0;
            3: begin
                sd = (d >= HALF) ? d - FULL : d;
                a  = (sd < 0) ? -sd : sd;
                if (a > HALF - 1) a = HALF - 1;
                return a;
            end
            default: return d;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // one clock: sample handshakes, update model, cross the edge
    task automatic step();
        exp_t e;
        bit   xfer;
        #1;
        last_acc = in_valid && in_ready;
        xfer     = out_valid && out_ready;
        if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_od);
            chk("hold_hit", out_hit, prev_oh);
        end
        if (rst) begin
            q.delete();
            cnt_m = 0;
        end else begin
            if (xfer) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_hit", out_hit, e.hit);
                    // measured from the cycle the sample is presented
                    if (lat_chk) chk("latency", cyc - e.cyc, 2);
                    if (e.hit != 0 && cnt_m < CMAX) cnt_m++;
                end
            end
            if (cnt_clr) cnt_m = 0;
            if (last_acc) begin
                e.data = ref_xform(int'(in_data), int'(in_mode),
                                   int'(in_lo), int'(in_hi));
                e.hit  = (e.data != int'(in_data)) ? 1 : 0;
                e.cyc  = cyc;
                q.push_back(e);
            end
        end
        prev_hold = !rst && out_valid && !out_ready;
        prev_od   = out_data;
        prev_oh   = out_hit;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("hit_cnt", hit_cnt, cnt_m);
    endtask

    task automatic send(int d, int m, int lo, int hi);
        in_valid = 1'b1;
        in_data  = d[W-1:0];
        in_mode  = m[1:0];
        in_lo    = lo[W-1:0];
        in_hi    = hi[W-1:0];
        for (int i = 0; i < 64; i++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (q.size() == 0) break;
            step();
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int vals[4];
        int k;
        vals = '{3, 7, 11, 14};

        @(negedge clk);
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_hit", out_hit, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_in_ready", in_ready, 1);

        out_ready = 1'b1;
        lat_chk   = 1'b1;
        send(0, 0, 0, 0);
        send(9, 0, 0, 0);
        send(10, 0, 0, 0);
        send(5, 0, 0, 0);
        drain();
        chk("pass_cnt", hit_cnt, 0);

        send(1, 1, 3, 8);
        send(5, 1, 3, 8);
        send(12, 1, 3, 8);
        drain();
        chk("clamp_cnt", hit_cnt, 2);

        send(5, 2, 6, 0);
        send(6, 2, 6, 0);
        send(9, 3, 0, 0);
        send(8, 3, 0, 0);
        send(3, 3, 0, 0);
        drain();
        chk("thr_abs_cnt", hit_cnt, 5);
        lat_chk = 1'b0;

        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = vals[k][W-1:0];
            in_mode  = 2'd0;
            step();
            if (last_acc) k++;
        end
        chk("stall_accepted", k, 2);
        chk("stall_in_ready", in_ready, 0);
        out_ready = 1'b1;
        while (k < 4) begin
            send(vals[k], 0, 0, 0);
            k++;
        end
        drain();

        for (int i = 0; i < 300; i++) send(0, 1, 5, 9);
        drain();
        chk("sat_cnt", hit_cnt, CMAX);

        out_ready = 1'b0;
        send(0, 1, 5, 9);
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_wins_cnt", hit_cnt, 0);
        chk("clr_xfer_done", q.size(), 0);

        send(2, 1, 5, 9);
        drain();
        out_ready = 1'b0;
        send(0, 1, 5, 9);
        send(1, 1, 5, 9);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_cnt", hit_cnt, 0);
        chk("mid_rst_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (5) step();

        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom_range(0, FULL - 1));
            in_mode   = 2'($urandom_range(0, 3));
            in_lo     = W'($urandom_range(0, FULL - 1));
            in_hi     = W'($urandom_range(0, FULL - 1));
            out_ready = 1'($urandom_range(0, 1));
            cnt_clr   = ($urandom_range(0, 19) == 0);
            step();
        end
        cnt_clr = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
